// File: rtl/mantissa_multiplier.sv
// mantissa_multiplier
//   Sequential 24x24 unsigned mantissa multiplier for the single-precision
//   multiply datapath. Restores the hidden leading one on both fractions and
//   forms the exact 48-bit product by radix-2 shift-and-add, one multiplier
//   bit per cycle. It takes 24 iterations, and the registered product comes
//   with a one-cycle done pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; product holds the last result
//   RUN   | one shift-and-add iteration per cycle, cnt = iterations done
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   request, sampled only in IDLE
//   a_mant  in   MANT_W-bit fraction of operand A (no hidden bit)
//   b_mant  in   MANT_W-bit fraction of operand B (no hidden bit)
//   busy    out  high while a multiplication is in progress
//   done    out  one-cycle pulse, product valid from this cycle on
//   product out  {1,a_mant} * {1,b_mant}, 2*(MANT_W+1) bits, registered

module mantissa_multiplier #(
    parameter int MANT_W = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [MANT_W-1:0]       a_mant,
    input  logic [MANT_W-1:0]       b_mant,
    output logic                    busy,
    output logic                    done,
    output logic [2*(MANT_W+1)-1:0] product
);

    localparam int OP_W   = MANT_W + 1;
    localparam int PROD_W = 2 * OP_W;
    localparam int CNT_W  = $clog2(OP_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [OP_W-1:0]  mcand;
    logic [OP_W-1:0]  mplier;
    // Upper half of the running product. The carry out of each add lives in
    // sum for one cycle and is shifted straight into the top bit here, so
    // the bit above it is always zero and is not stored.
    logic [OP_W-1:0]  acc;
    logic [CNT_W-1:0] cnt;
    logic [OP_W:0]    sum;

    logic load;
    logic step;
    logic last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(MANT_W)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sum  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(OP_W+1){1'b0}});
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= last;
            if (load) begin
                mcand  <= {1'b1, a_mant};
                mplier <= {1'b1, b_mant};
                acc    <= '0;
                cnt    <= '0;
            end else if (step) begin
                // {sum, mplier} >> 1: the add result drops into acc, its
                // lsb enters the top of mplier as the consumed bit leaves.
                acc    <= sum[OP_W:1];
                mplier <= {sum[0], mplier[OP_W-1:1]};
                cnt    <= cnt + CNT_W'(1);
            end
            if (last) begin
                product <= PROD_W'({sum[OP_W:1], sum[0], mplier[OP_W-1:1]});
            end
        end
    end

endmodule

// File: tb/tb_mantissa_multiplier.sv
module tb_mantissa_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [22:0] a_mant;
    logic [22:0] b_mant;
    logic        busy;
    logic        done;
    logic [47:0] product;

    int n_checks = 0;
    int n_fails  = 0;
    logic [47:0] exp_q[$];

    mantissa_multiplier #(.MANT_W(23)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a_mant  (a_mant),
        .b_mant  (b_mant),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] ref_mul(input logic [22:0] a, input logic [22:0] b);
        logic [47:0] ma, mb;
        ma = 48'({1'b1, a});
        mb = 48'({1'b1, b});
        return ma * mb;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 64'(done), 64'(0));
            end else begin
                check_val("product", 64'(product), 64'(exp_q.pop_front()));
            end
        end
    end

    // One operation. Optionally pulses start (new operands) at E5 and E12,
    // which must be ignored. Checks latency, busy and product stability.
    task automatic run_op(input logic [22:0] a, input logic [22:0] b, input bit glitch);
        int          lat;
        logic [47:0] held;
        held = product;
        @(negedge clk);
        a_mant = a;
        b_mant = b;
        start  = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        @(negedge clk);
        start  = 1'b0;
        a_mant = 23'($urandom);
        b_mant = 23'($urandom);
        lat = 1;
        check_val("busy_rise", 64'(busy), 64'(1));
        while (!done && lat < 40) begin
            if (lat == 20) check_val("product_held", 64'(product), 64'(held));
            start = glitch && (lat == 5 || lat == 12);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_val("done_latency", 64'(lat), 64'(25));
        check_val("busy_fall", 64'(busy), 64'(0));
        @(negedge clk);
        check_val("done_pulse_width", 64'(done), 64'(0));
    endtask

    initial begin
        int lat;
        reset  = 1'b1;
        start  = 1'b0;
        a_mant = '0;
        b_mant = '0;
        repeat (2) @(negedge clk);
        check_val("reset_busy", 64'(busy), 64'(0));
        check_val("reset_done", 64'(done), 64'(0));
        check_val("reset_product", 64'(product), 64'(0));
        reset = 1'b0;

        run_op(23'h000000, 23'h000000, 1'b0);
        check_val("one_times_one", 64'(product), 64'h400000000000);
        run_op(23'h400000, 23'h400000, 1'b0);
        check_val("onefive_sq", 64'(product), 64'h900000000000);
        check_val("onefive_msb", 64'(product[47]), 64'(1));
        run_op(23'h7FFFFF, 23'h7FFFFF, 1'b0);
        check_val("max_sq", 64'(product), 64'hFFFFFE000001);
        run_op(23'h000001, 23'h000000, 1'b0);
        check_val("lsb_case", 64'(product), 64'h400000800000);

        // Restart attempts during RUN are ignored; the next run also checks
        // that this result stays put until it completes.
        run_op(23'h123456, 23'h654321, 1'b1);
        check_val("glitch_result", 64'(product), 64'(ref_mul(23'h123456, 23'h654321)));
        run_op(23'h2AAAAA, 23'h555555, 1'b0);

        // Reset in the middle of a run.
        @(negedge clk);
        a_mant = 23'h0F0F0F;
        b_mant = 23'h70F0F0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("midrun_reset_busy", 64'(busy), 64'(0));
        check_val("midrun_reset_done", 64'(done), 64'(0));
        check_val("midrun_reset_product", 64'(product), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check_val("no_done_after_reset", 64'(product), 64'(0));
        run_op(23'h0F0F0F, 23'h70F0F0, 1'b0);

        // start held high: back-to-back operations every 25 cycles.
        @(negedge clk);
        a_mant = 23'($urandom);
        b_mant = 23'($urandom);
        start  = 1'b1;
        exp_q.push_back(ref_mul(a_mant, b_mant));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lat = 1;
            while (!done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check_val("b2b_latency", 64'(lat), 64'(25));
            if (k < 3) begin
                a_mant = 23'($urandom);
                b_mant = 23'($urandom);
                exp_q.push_back(ref_mul(a_mant, b_mant));
            end else begin
                start = 1'b0;
            end
        end
        repeat (30) @(negedge clk);
        check_val("queue_drained", 64'(exp_q.size()), 64'(0));
        check_val("final_idle", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
